// File: rtl/pipo_shift_pkg.sv
// rtl/pipo_shift_pkg.sv - shared types for the PIPO shift sequencer
//   shift_mode_t : fill policy applied on each shift step
//   state_t      : sequencer FSM states
//   DIR_RIGHT / DIR_LEFT : encoding of the dir input
package pipo_shift_pkg;

    typedef enum logic [1:0] {
        LOGICAL = 2'd0,
        ARITH   = 2'd1,
        ROTATE  = 2'd2,
        SERIAL  = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/pipo_shift_seq_shift_step.sv
// rtl/pipo_shift_seq_shift_step.sv - combinational single-bit shift step
//   word        in   N   current register contents
//   dir         in   1   0 = right (toward LSB), 1 = left
//   mode        in   2   fill policy
//   serial_in   in   1   fill bit used in SERIAL mode
//   next_word   out  N   register contents after one step
//   shifted_out out  1   bit that leaves the register on this step
module shift_step
    import pipo_shift_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] word,
    input  logic         dir,
    input  shift_mode_t  mode,
    input  logic         serial_in,
    output logic [N-1:0] next_word,
    output logic         shifted_out
);

    logic fill;

    always_comb begin
        fill        = 1'b0;
        next_word   = word;
        shifted_out = 1'b0;
        if (dir == DIR_RIGHT) begin
            case (mode)
                LOGICAL: fill = 1'b0;
                ARITH:   fill = word[N-1];
                ROTATE:  fill = word[0];
                SERIAL:  fill = serial_in;
                default: fill = 1'b0;
            endcase
            next_word   = {fill, word[N-1:1]};
            shifted_out = word[0];
        end else begin
            // Left arithmetic shift is identical to logical: zero enters at the LSB.
            case (mode)
                LOGICAL: fill = 1'b0;
                ARITH:   fill = 1'b0;
                ROTATE:  fill = word[N-1];
                SERIAL:  fill = serial_in;
                default: fill = 1'b0;
            endcase
            next_word   = {word[N-2:0], fill};
            shifted_out = word[N-1];
        end
    end

endmodule

// File: rtl/pipo_shift_seq.sv
// rtl/pipo_shift_seq.sv - multi-mode PIPO shift register sequenced one bit per cycle
//   clk, reset_n  clock, asynchronous active-low reset
//   in            parallel load word
//   amount        shift count, values above N clamp to N
//   mode, dir     fill policy and direction, latched on accept
//   serial_in     fill bit for SERIAL mode, sampled on every step
//   load_valid / load_ready  operation request handshake (ready only in IDLE)
//   stall         freezes an operation in progress
//   clear         synchronous abort, zeroes the register
//   out           low OUT_BITS of the register
//   serial_out    bit shifted off on the most recent step
//   busy          high while shifting
//   done          one-cycle completion pulse
module pipo_shift_seq
    import pipo_shift_pkg::*;
#(
    parameter int N        = 16,
    parameter int OUT_BITS = N,
    parameter int CNT_W    = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        in,
    input  logic [CNT_W-1:0]    amount,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic                serial_in,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                stall,
    input  logic                clear,
    output logic [OUT_BITS-1:0] out,
    output logic                serial_out,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     word_q, word_d;
    shift_mode_t      mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             serial_out_q, serial_out_d;

    logic [CNT_W-1:0] amount_clamped;
    logic [N-1:0]     step_word;
    logic             step_bit;

    // Step always works from the latched mode/dir so that input changes
    // after the accept cannot disturb an operation in flight.
    shift_step #(
        .N (N)
    ) u_shift_step (
        .word        (word_q),
        .dir         (dir_q),
        .mode        (mode_q),
        .serial_in   (serial_in),
        .next_word   (step_word),
        .shifted_out (step_bit)
    );

    assign amount_clamped = (amount > N_CNT) ? N_CNT : amount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_q       <= '0;
            mode_q       <= LOGICAL;
            dir_q        <= DIR_RIGHT;
            serial_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_q       <= word_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            serial_out_q <= serial_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_d       = word_q;
        mode_d       = mode_q;
        dir_d        = dir_q;
        serial_out_d = serial_out_q;

        if (clear) begin
            // Abort wins over everything, including a simultaneous request.
            state_d      = IDLE;
            count_d      = '0;
            word_d       = '0;
            serial_out_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        word_d  = in;
                        mode_d  = shift_mode_t'(mode);
                        dir_d   = dir;
                        count_d = amount_clamped;
                        state_d = (amount_clamped == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (!stall) begin
                        word_d       = step_word;
                        serial_out_d = step_bit;
                        count_d      = count_q - ONE;
                        if (count_q == ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign out        = word_q[OUT_BITS-1:0];
    assign serial_out = serial_out_q;

endmodule
